// File: rtl/axil_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to register-file bridge.
package axil_reg_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    localparam int TO_CNT_W = 8;

endpackage

// File: rtl/axil_reg_bridge_hold_reg.sv
// Single-entry valid/ready holding register; ready is registered as the inverse of the held flag.
module axil_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             ready,
    input  logic             clr,
    output logic             held,
    output logic [WIDTH-1:0] out_data
);

    logic             held_r;
    logic             ready_r;
    logic [WIDTH-1:0] data_r;
    logic             held_next_s;
    logic             hs_s;

    assign hs_s     = in_valid && ready_r;
    assign ready    = ready_r;
    assign held     = held_r;
    assign out_data = data_r;

    // Next held flag: a consume and a capture can never coincide since ready implies empty
    always_comb begin
        held_next_s = held_r;
        if (clr) begin
            held_next_s = 1'b0;
        end else if (hs_s) begin
            held_next_s = 1'b1;
        end else begin
            held_next_s = held_r;
        end
    end

    // Holding state, payload capture and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_r  <= 1'b0;
            ready_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            held_r  <= held_next_s;
            ready_r <= !held_next_s;
            if (hs_s) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end
    end

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that turns each transaction into one held register request with a watchdog.
module axil_reg_bridge
    import axil_reg_pkg::*;
#(
    parameter int AXI_AWIDTH = 12,
    parameter int AXI_DWIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AXI_AWIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [AXI_DWIDTH-1:0]   WDATA,
    input  logic [AXI_DWIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic                    BVALID,
    output logic [1:0]              BRESP,
    input  logic                    BREADY,
    input  logic [AXI_AWIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic                    RVALID,
    output logic [AXI_DWIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    input  logic                    RREADY,
    output logic                    reg_wr_en,
    output logic                    reg_rd_en,
    output logic [AXI_AWIDTH-1:0]   reg_addr,
    output logic [AXI_DWIDTH-1:0]   reg_wdata,
    output logic [AXI_DWIDTH/8-1:0] reg_wstrb,
    input  logic [AXI_DWIDTH-1:0]   reg_rdata,
    input  logic                    reg_ack,
    input  logic                    reg_err
);

    localparam int SW = AXI_DWIDTH / 8;
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    state_t                  state_r;
    logic                    prio_wr_r;
    logic [TO_CNT_W-1:0]     cnt_r;
    logic [AXI_AWIDTH-1:0]   aw_addr_s;
    logic [AXI_AWIDTH-1:0]   ar_addr_s;
    logic [AXI_DWIDTH+SW-1:0] w_data_s;
    logic                    aw_held_s;
    logic                    w_held_s;
    logic                    ar_held_s;
    logic                    wr_pend_s;
    logic                    rd_pend_s;
    logic                    to_hit_s;
    logic                    wr_done_s;
    logic                    rd_done_s;
    logic                    unused_prot_s;

    assign unused_prot_s = ^{AWPROT, ARPROT};
    assign wr_pend_s     = aw_held_s && w_held_s;
    assign rd_pend_s     = ar_held_s;
    assign to_hit_s      = (cnt_r == TO_LAST);

    // Completion of the in-flight access releases the holding registers it consumed
    always_comb begin
        wr_done_s = 1'b0;
        rd_done_s = 1'b0;
        case (state_r)
            WR_REQ:  wr_done_s = reg_ack || to_hit_s;
            RD_REQ:  rd_done_s = reg_ack || to_hit_s;
            default: begin
                wr_done_s = 1'b0;
                rd_done_s = 1'b0;
            end
        endcase
    end

    axil_hold_reg #(.WIDTH(AXI_AWIDTH)) u_aw_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (AWADDR),
        .in_valid (AWVALID),
        .ready    (AWREADY),
        .clr      (wr_done_s),
        .held     (aw_held_s),
        .out_data (aw_addr_s)
    );

    axil_hold_reg #(.WIDTH(AXI_DWIDTH + SW)) u_w_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  ({WSTRB, WDATA}),
        .in_valid (WVALID),
        .ready    (WREADY),
        .clr      (wr_done_s),
        .held     (w_held_s),
        .out_data (w_data_s)
    );

    axil_hold_reg #(.WIDTH(AXI_AWIDTH)) u_ar_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (ARADDR),
        .in_valid (ARVALID),
        .ready    (ARREADY),
        .clr      (rd_done_s),
        .held     (ar_held_s),
        .out_data (ar_addr_s)
    );

    // Transaction FSM: arbitration, register request, watchdog and AXI responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            prio_wr_r <= 1'b1;
            cnt_r     <= {TO_CNT_W{1'b0}};
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= {AXI_AWIDTH{1'b0}};
            reg_wdata <= {AXI_DWIDTH{1'b0}};
            reg_wstrb <= {SW{1'b0}};
            BVALID    <= 1'b0;
            BRESP     <= OKAY;
            RVALID    <= 1'b0;
            RRESP     <= OKAY;
            RDATA     <= {AXI_DWIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= {TO_CNT_W{1'b0}};
                    // The pointer always names the side that did not win last time
                    if (wr_pend_s && (!rd_pend_s || prio_wr_r)) begin
                        state_r   <= WR_REQ;
                        prio_wr_r <= 1'b0;
                        reg_wr_en <= 1'b1;
                        reg_addr  <= aw_addr_s;
                        reg_wdata <= w_data_s[AXI_DWIDTH-1:0];
                        reg_wstrb <= w_data_s[AXI_DWIDTH+SW-1:AXI_DWIDTH];
                    end else if (rd_pend_s) begin
                        state_r   <= RD_REQ;
                        prio_wr_r <= 1'b1;
                        reg_rd_en <= 1'b1;
                        reg_addr  <= ar_addr_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (reg_ack) begin
                        reg_wr_en <= 1'b0;
                        BVALID    <= 1'b1;
                        BRESP     <= reg_err ? SLVERR : OKAY;
                        state_r   <= WR_RESP;
                    end else if (to_hit_s) begin
                        reg_wr_en <= 1'b0;
                        BVALID    <= 1'b1;
                        BRESP     <= SLVERR;
                        state_r   <= WR_RESP;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (reg_ack) begin
                        reg_rd_en <= 1'b0;
                        RVALID    <= 1'b1;
                        RRESP     <= reg_err ? SLVERR : OKAY;
                        RDATA     <= reg_rdata;
                        state_r   <= RD_RESP;
                    end else if (to_hit_s) begin
                        reg_rd_en <= 1'b0;
                        RVALID    <= 1'b1;
                        RRESP     <= SLVERR;
                        RDATA     <= {AXI_DWIDTH{1'b0}};
                        state_r   <= RD_RESP;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= WR_RESP;
                    end
                end
                RD_RESP: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= RD_RESP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    reg_wr_en <= 1'b0;
                    reg_rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
